// File: rtl/cam_capture.sv
// OV7670 parallel-bus capture: synchronises the camera bus into clk, pairs bytes into
// RGB565 pixels and emits them with a linear frame-buffer write address.
module cam_capture #(
    parameter int H_PIX   = 640,
    parameter int V_LINES = 480,
    parameter int ADDR_W  = 19
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              done_cam_config_i,
    input  logic              cam_pclk_i,
    input  logic              cam_vsync_i,
    input  logic              cam_href_i,
    input  logic [7:0]        cam_data_i,
    output logic [15:0]       pix_data_o,
    output logic [ADDR_W-1:0] pix_addr_o,
    output logic              pix_valid_o,
    output logic              frame_done_o,
    output logic              overflow_o
);

    localparam logic [ADDR_W-1:0] TOTAL_PIX = ADDR_W'(H_PIX * V_LINES);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        CAPTURE    = 2'd2
    } state_t;

    // bit 0/1 form the synchroniser, bit 2 is the history flop for edge detection
    logic [2:0]        pclk_sync_q, vsync_sync_q, href_sync_q;
    logic [7:0]        data_s1_q, data_s2_q;

    logic              ev_pclk_q, ev_vrise_q, ev_vfall_q, ev_hfall_q, ev_href_q;
    logic [7:0]        ev_data_q;

    state_t            state_q, state_d;
    logic              phase_q, phase_d;
    logic [7:0]        hi_q, hi_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              emit_q, emit_d;
    logic [15:0]       emit_data_q, emit_data_d;
    logic [ADDR_W-1:0] emit_addr_q, emit_addr_d;
    logic              ovf_q, ovf_d;
    logic              fdone_q, fdone_d;

    logic [15:0]       pix_data_q;
    logic [ADDR_W-1:0] pix_addr_q;
    logic              pix_valid_q;

    // Input synchronisers and registered edge events
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pclk_sync_q  <= 3'b000;
            vsync_sync_q <= 3'b000;
            href_sync_q  <= 3'b000;
            data_s1_q    <= 8'h00;
            data_s2_q    <= 8'h00;
            ev_pclk_q    <= 1'b0;
            ev_vrise_q   <= 1'b0;
            ev_vfall_q   <= 1'b0;
            ev_hfall_q   <= 1'b0;
            ev_href_q    <= 1'b0;
            ev_data_q    <= 8'h00;
        end else begin
            pclk_sync_q  <= {pclk_sync_q[1:0], cam_pclk_i};
            vsync_sync_q <= {vsync_sync_q[1:0], cam_vsync_i};
            href_sync_q  <= {href_sync_q[1:0], cam_href_i};
            data_s1_q    <= cam_data_i;
            data_s2_q    <= data_s1_q;
            ev_pclk_q    <= pclk_sync_q[1] & ~pclk_sync_q[2];
            ev_vrise_q   <= vsync_sync_q[1] & ~vsync_sync_q[2];
            ev_vfall_q   <= ~vsync_sync_q[1] & vsync_sync_q[2];
            ev_hfall_q   <= ~href_sync_q[1] & href_sync_q[2];
            ev_href_q    <= href_sync_q[1];
            ev_data_q    <= data_s2_q;
        end
    end

    // FSM and capture-state registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            phase_q     <= 1'b0;
            hi_q        <= 8'h00;
            cnt_q       <= '0;
            emit_q      <= 1'b0;
            emit_data_q <= 16'h0000;
            emit_addr_q <= '0;
            ovf_q       <= 1'b0;
            fdone_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            hi_q        <= hi_d;
            cnt_q       <= cnt_d;
            emit_q      <= emit_d;
            emit_data_q <= emit_data_d;
            emit_addr_q <= emit_addr_d;
            ovf_q       <= ovf_d;
            fdone_q     <= fdone_d;
        end
    end

    // Next-state, byte pairing and address/overflow bookkeeping
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        hi_d        = hi_q;
        cnt_d       = cnt_q;
        emit_d      = 1'b0;
        emit_data_d = emit_data_q;
        emit_addr_d = emit_addr_q;
        ovf_d       = ovf_q;
        fdone_d     = 1'b0;
        if (!done_cam_config_i) begin
            state_d = IDLE;
            phase_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT_FRAME;
                end
                WAIT_FRAME: begin
                    if (ev_vfall_q) begin
                        state_d = CAPTURE;
                        cnt_d   = '0;
                        phase_d = 1'b0;
                    end else begin
                        state_d = WAIT_FRAME;
                    end
                end
                CAPTURE: begin
                    // vsync rise takes priority over any pixel completing in the same cycle
                    if (ev_vrise_q) begin
                        state_d = WAIT_FRAME;
                        fdone_d = 1'b1;
                        phase_d = 1'b0;
                    end else if (ev_pclk_q && ev_href_q) begin
                        if (!phase_q) begin
                            hi_d    = ev_data_q;
                            phase_d = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            if (cnt_q < TOTAL_PIX) begin
                                emit_d      = 1'b1;
                                emit_data_d = {hi_q, ev_data_q};
                                emit_addr_d = cnt_q;
                                cnt_d       = cnt_q + ADDR_W'(1);
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end
                    end else if (ev_hfall_q) begin
                        phase_d = 1'b0;
                    end else begin
                        phase_d = phase_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output register stage
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pix_valid_q <= 1'b0;
            pix_data_q  <= 16'h0000;
            pix_addr_q  <= '0;
        end else begin
            pix_valid_q <= emit_q;
            if (emit_q) begin
                pix_data_q <= emit_data_q;
                pix_addr_q <= emit_addr_q;
            end
        end
    end

    assign pix_valid_o  = pix_valid_q;
    assign pix_data_o   = pix_data_q;
    assign pix_addr_o   = pix_addr_q;
    assign frame_done_o = fdone_q;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture with a tiny 4x2 frame and a pclk = clk/4 bus model.
module tb_cam_capture;

    localparam int H_PIX   = 4;
    localparam int V_LINES = 2;
    localparam int ADDR_W  = 19;

    logic              clk;
    logic              rst;
    logic              done_cfg;
    logic              pclk, vsync, href;
    logic [7:0]        data;
    logic [15:0]       pix_data;
    logic [ADDR_W-1:0] pix_addr;
    logic              pix_valid, frame_done, overflow;

    int checks = 0;
    int fails  = 0;

    logic [15:0]       q_data[$];
    logic [ADDR_W-1:0] q_addr[$];
    int                fd_cnt = 0;

    cam_capture #(.H_PIX(H_PIX), .V_LINES(V_LINES), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .rst_i(rst), .done_cam_config_i(done_cfg),
        .cam_pclk_i(pclk), .cam_vsync_i(vsync), .cam_href_i(href), .cam_data_i(data),
        .pix_data_o(pix_data), .pix_addr_o(pix_addr), .pix_valid_o(pix_valid),
        .frame_done_o(frame_done), .overflow_o(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every strobe seen on the outputs
    always @(negedge clk) begin
        if (pix_valid) begin
            q_data.push_back(pix_data);
            q_addr.push_back(pix_addr);
        end
        if (frame_done) fd_cnt++;
    end

    function automatic logic [7:0] byte_at(input int k);
        logic [7:0] b;
        b = 8'h12 + 8'(k * 34);
        return b;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        q_data.delete();
        q_addr.delete();
        fd_cnt = 0;
    endtask

    task automatic bus_byte(input logic [7:0] b);
        data = b; pclk = 1'b0; tick(2);
        pclk = 1'b1; tick(2);
    endtask

    task automatic send_line(input int nbytes, input int k0);
        href = 1'b1;
        for (int i = 0; i < nbytes; i++) bus_byte(byte_at(k0 + i));
        pclk = 1'b0; tick(2);
        href = 1'b0; tick(6);
    endtask

    task automatic frame_start();
        vsync = 1'b1; tick(8);
        vsync = 1'b0; tick(8);
    endtask

    task automatic frame_end();
        vsync = 1'b1; tick(12);
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(3);
        checks++; if (pix_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", pix_valid); end
        checks++; if (pix_data !== 16'h0000) begin fails++; $display("FAIL reset_data: got %h expected 0000", pix_data); end
        checks++; if (pix_addr !== 19'd0) begin fails++; $display("FAIL reset_addr: got %0d expected 0", pix_addr); end
        checks++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_fdone: got %b expected 0", frame_done); end
        checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
        rst = 1'b0; tick(2);
    endtask

    task automatic test_latency();
        done_cfg = 1'b1; tick(2);
        clear_mon();
        frame_start();
        href = 1'b1;
        bus_byte(8'hAB);
        data = 8'hCD; pclk = 1'b0; tick(2);
        pclk = 1'b1; tick(4);
        checks++; if (pix_valid !== 1'b0) begin fails++; $display("FAIL latency_early: got %b expected 0 at edge 3", pix_valid); end
        tick(1);
        checks++; if (pix_valid !== 1'b1) begin fails++; $display("FAIL latency_edge4: got %b expected 1", pix_valid); end
        checks++; if (pix_data !== 16'hABCD) begin fails++; $display("FAIL latency_data: got %h expected abcd", pix_data); end
        checks++; if (pix_addr !== 19'd0) begin fails++; $display("FAIL latency_addr: got %0d expected 0", pix_addr); end
        tick(1);
        checks++; if (pix_valid !== 1'b0) begin fails++; $display("FAIL latency_strobe_width: got %b expected 0", pix_valid); end
        checks++; if (pix_data !== 16'hABCD) begin fails++; $display("FAIL latency_hold: got %h expected abcd", pix_data); end
        pclk = 1'b0; tick(2);
        href = 1'b0; tick(4);
        frame_end();
        checks++; if (fd_cnt !== 1) begin fails++; $display("FAIL short_frame_fdone: got %0d expected 1", fd_cnt); end
    endtask

    task automatic test_full_frame();
        logic [15:0] exp;
        clear_mon();
        frame_start();
        send_line(8, 0);
        send_line(8, 8);
        frame_end();
        checks++; if (q_data.size() !== 8) begin fails++; $display("FAIL full_count: got %0d expected 8", q_data.size()); end
        for (int i = 0; i < 8 && i < q_data.size(); i++) begin
            exp = {byte_at(2 * i), byte_at(2 * i + 1)};
            checks++; if (q_data[i] !== exp) begin fails++; $display("FAIL full_data[%0d]: got %h expected %h", i, q_data[i], exp); end
            checks++; if (q_addr[i] !== 19'(i)) begin fails++; $display("FAIL full_addr[%0d]: got %0d expected %0d", i, q_addr[i], i); end
        end
        checks++; if (q_data.size() > 1 && q_data[1] !== 16'h5678) begin fails++; $display("FAIL full_px1: got %h expected 5678", q_data[1]); end
        checks++; if (fd_cnt !== 1) begin fails++; $display("FAIL full_fdone: got %0d expected 1", fd_cnt); end
        checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL full_ovf: got %b expected 0", overflow); end
    endtask

    task automatic test_odd_line();
        clear_mon();
        frame_start();
        send_line(3, 0);
        send_line(4, 10);
        frame_end();
        checks++; if (q_data.size() !== 3) begin fails++; $display("FAIL odd_count: got %0d expected 3", q_data.size()); end
        if (q_data.size() == 3) begin
            checks++; if (q_data[0] !== 16'h1234) begin fails++; $display("FAIL odd_px0: got %h expected 1234", q_data[0]); end
            checks++; if (q_data[1] !== {byte_at(10), byte_at(11)}) begin fails++; $display("FAIL odd_px1: got %h expected %h", q_data[1], {byte_at(10), byte_at(11)}); end
            checks++; if (q_addr[2] !== 19'd2) begin fails++; $display("FAIL odd_addr2: got %0d expected 2", q_addr[2]); end
        end
    endtask

    task automatic test_disabled();
        done_cfg = 1'b0; tick(2);
        clear_mon();
        frame_start();
        send_line(8, 0);
        send_line(8, 8);
        frame_end();
        checks++; if (q_data.size() !== 0) begin fails++; $display("FAIL disabled_pix: got %0d expected 0", q_data.size()); end
        checks++; if (fd_cnt !== 0) begin fails++; $display("FAIL disabled_fdone: got %0d expected 0", fd_cnt); end
    endtask

    task automatic test_enable_midframe();
        clear_mon();
        vsync = 1'b1; tick(8);
        vsync = 1'b0; tick(8);
        done_cfg = 1'b1; tick(2);
        send_line(8, 0);
        frame_end();
        checks++; if (q_data.size() !== 0) begin fails++; $display("FAIL midframe_pix: got %0d expected 0", q_data.size()); end
        checks++; if (fd_cnt !== 0) begin fails++; $display("FAIL midframe_fdone: got %0d expected 0", fd_cnt); end
        frame_start();
        send_line(4, 20);
        frame_end();
        checks++; if (q_data.size() !== 2) begin fails++; $display("FAIL nextframe_count: got %0d expected 2", q_data.size()); end
        if (q_data.size() == 2) begin
            checks++; if (q_addr[0] !== 19'd0 || q_data[0] !== {byte_at(20), byte_at(21)}) begin fails++; $display("FAIL nextframe_px0: got %h@%0d expected %h@0", q_data[0], q_addr[0], {byte_at(20), byte_at(21)}); end
        end
        checks++; if (fd_cnt !== 1) begin fails++; $display("FAIL nextframe_fdone: got %0d expected 1", fd_cnt); end
    endtask

    task automatic test_overflow();
        clear_mon();
        frame_start();
        send_line(10, 0);
        checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_early: got %b expected 0", overflow); end
        send_line(10, 10);
        frame_end();
        checks++; if (q_data.size() !== 8) begin fails++; $display("FAIL ovf_count: got %0d expected 8", q_data.size()); end
        if (q_addr.size() == 8) begin
            checks++; if (q_addr[7] !== 19'd7) begin fails++; $display("FAIL ovf_last_addr: got %0d expected 7", q_addr[7]); end
        end
        checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        checks++; if (fd_cnt !== 1) begin fails++; $display("FAIL ovf_fdone: got %0d expected 1", fd_cnt); end
        clear_mon();
        frame_start();
        send_line(4, 0);
        frame_end();
        checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_rst_midframe();
        clear_mon();
        frame_start();
        href = 1'b1;
        for (int i = 0; i < 6; i++) bus_byte(byte_at(i));
        pclk = 1'b0; tick(6);
        checks++; if (q_data.size() !== 3) begin fails++; $display("FAIL rst_pre_count: got %0d expected 3", q_data.size()); end
        rst = 1'b1; tick(1);
        checks++; if ({pix_valid, frame_done, overflow} !== 3'b000) begin fails++; $display("FAIL rst_flags: got %b expected 000", {pix_valid, frame_done, overflow}); end
        checks++; if (pix_data !== 16'h0000 || pix_addr !== 19'd0) begin fails++; $display("FAIL rst_data_addr: got %h@%0d expected 0000@0", pix_data, pix_addr); end
        rst = 1'b0;
        href = 1'b0; tick(4);
        clear_mon();
        frame_end();
        checks++; if (fd_cnt !== 0) begin fails++; $display("FAIL rst_no_fdone: got %0d expected 0", fd_cnt); end
        frame_start();
        send_line(4, 4);
        frame_end();
        checks++; if (q_addr.size() !== 2) begin fails++; $display("FAIL rst_new_count: got %0d expected 2", q_addr.size()); end
        if (q_addr.size() == 2) begin
            checks++; if (q_addr[0] !== 19'd0) begin fails++; $display("FAIL rst_new_addr: got %0d expected 0", q_addr[0]); end
            checks++; if (q_data[1] !== {byte_at(6), byte_at(7)}) begin fails++; $display("FAIL rst_new_data: got %h expected %h", q_data[1], {byte_at(6), byte_at(7)}); end
        end
        checks++; if (fd_cnt !== 1) begin fails++; $display("FAIL rst_new_fdone: got %0d expected 1", fd_cnt); end
    endtask

    initial begin
        rst = 1'b1; done_cfg = 1'b0;
        pclk = 1'b0; vsync = 1'b0; href = 1'b0; data = 8'h00;
        tick(2);
        test_reset();
        test_latency();
        test_full_frame();
        test_odd_line();
        test_disabled();
        test_enable_midframe();
        test_overflow();
        test_rst_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
